// File: rtl/imem_preloader.sv
// ============================================================================
// Module   : imem_preloader
// Purpose  : Boot loader that streams a length-prefixed byte image into the
//            instruction memory preload port, holding the CPU in reset meanwhile.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_preloader #(
   parameter int N    = 1024,
   parameter int BASE = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic        byte_ready,
   output logic        pre_ld,
   output logic [31:0] pre_A,
   output logic [31:0] pre_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        cpu_rst
);

   localparam logic [2:0] c_idle  = 3'd0;
   localparam logic [2:0] c_len0  = 3'd1;
   localparam logic [2:0] c_len1  = 3'd2;
   localparam logic [2:0] c_data  = 3'd3;
   localparam logic [2:0] c_write = 3'd4;
   localparam logic [2:0] c_done  = 3'd5;
   localparam logic [2:0] c_err   = 3'd6;

   localparam logic [31:0] c_base      = 32'(BASE);
   localparam logic [16:0] c_max_words = 17'(N / 4);

   logic [2:0]  r_state;
   logic [2:0]  w_state_next;
   logic [15:0] r_count;
   logic [15:0] r_word_cnt;
   logic [1:0]  r_byte_cnt;
   logic [31:0] r_pre_a;
   logic [31:0] r_pre_data;
   logic        w_accept;
   logic [15:0] w_count_full;
   logic [15:0] w_word_next;

   assign w_accept     = byte_valid & byte_ready;
   // The high count byte is decided on in the same cycle it is accepted.
   assign w_count_full = {byte_in, r_count[7:0]};
   assign w_word_next  = r_word_cnt + 16'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_idle, c_done, c_err: begin
            if (start) w_state_next = c_len0;
         end
         c_len0: begin
            if (w_accept) w_state_next = c_len1;
         end
         c_len1: begin
            if (w_accept) begin
               if (w_count_full == 16'd0)
                  w_state_next = c_done;
               else if ({1'b0, w_count_full} > c_max_words)
                  w_state_next = c_err;
               else
                  w_state_next = c_data;
            end
         end
         c_data: begin
            if (w_accept && (r_byte_cnt == 2'd3)) w_state_next = c_write;
         end
         c_write: begin
            w_state_next = (w_word_next == r_count) ? c_done : c_data;
         end
         default: w_state_next = c_idle;
      endcase
   end

   always_comb begin
      byte_ready = 1'b0;
      pre_ld     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      cpu_rst    = 1'b1;
      case (r_state)
         c_len0, c_len1, c_data: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
         end
         c_write: begin
            pre_ld = 1'b1;
            busy   = 1'b1;
         end
         c_done: begin
            done    = 1'b1;
            cpu_rst = 1'b0;
         end
         c_err: begin
            err = 1'b1;
         end
         default: ;
      endcase
   end

   // Address/data only move outside WRITE, so they are stable under pre_ld.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count    <= 16'd0;
         r_word_cnt <= 16'd0;
         r_byte_cnt <= 2'd0;
         r_pre_a    <= c_base;
         r_pre_data <= 32'd0;
      end else begin
         case (r_state)
            c_idle, c_done, c_err: begin
               if (start) begin
                  r_word_cnt <= 16'd0;
                  r_byte_cnt <= 2'd0;
                  r_pre_a    <= c_base;
               end
            end
            c_len0: begin
               if (w_accept) r_count[7:0] <= byte_in;
            end
            c_len1: begin
               if (w_accept) r_count[15:8] <= byte_in;
            end
            c_data: begin
               if (w_accept) begin
                  r_pre_data[{r_byte_cnt, 3'b000} +: 8] <= byte_in;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
               end
            end
            c_write: begin
               r_pre_a    <= r_pre_a + 32'd4;
               r_word_cnt <= w_word_next;
            end
            default: ;
         endcase
      end
   end

   assign pre_A    = r_pre_a;
   assign pre_data = r_pre_data;

endmodule

`default_nettype wire

// File: tb/tb_imem_preloader.sv
// ============================================================================
// Module   : tb_imem_preloader
// Purpose  : Scoreboard bench for imem_preloader: expected preload writes are
//            queued as bytes are driven and popped on each pre_ld pulse.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_preloader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_in = 8'd0;
   logic        byte_ready;
   logic        pre_ld;
   logic [31:0] pre_A;
   logic [31:0] pre_data;
   logic        busy;
   logic        done;
   logic        err;
   logic        cpu_rst;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t_start = 0;
   logic prev_ld = 1'b0;
   logic [63:0] sb_q[$];

   imem_preloader #(.N(1024), .BASE(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_in    (byte_in),
      .byte_ready (byte_ready),
      .pre_ld     (pre_ld),
      .pre_A      (pre_A),
      .pre_data   (pre_data),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .cpu_rst    (cpu_rst)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Write monitor: every pre_ld must match the head of the scoreboard.
   always @(negedge clk) begin
      if (pre_ld) begin
         check_val("ld_twice", {63'd0, prev_ld}, 64'd0);
         if (sb_q.size() == 0) begin
            check_val("ld_unexp", {63'd0, pre_ld}, 64'd0);
         end else begin
            logic [63:0] e;
            e = sb_q.pop_front();
            check_val("ld_addr", {32'd0, pre_A},    {32'd0, e[63:32]});
            check_val("ld_data", {32'd0, pre_data}, {32'd0, e[31:0]});
         end
      end
      prev_ld = pre_ld;
   end

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      t_start = cyc;
   endtask

   task automatic send(input logic [7:0] b[$], input int gap, input bit chk_rdy);
      for (int i = 0; i < b.size(); i++) begin
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
         end
         if (chk_rdy && i >= 2) check_val("rdy_data", {63'd0, byte_ready}, 64'd1);
         byte_valid = 1'b1;
         byte_in    = b[i];
         for (int guard = 0; ; guard++) begin
            logic rdy;
            @(negedge clk); rdy = byte_ready;
            @(posedge clk); #1;
            if (rdy) break;
            if (guard > 200) begin
               check_val("timeout", 64'(guard), 64'd0);
               break;
            end
         end
         byte_valid = 1'b0;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_rdy"},  {63'd0, byte_ready}, 64'd0);
      check_val({tag, "_ld"},   {63'd0, pre_ld},     64'd0);
      check_val({tag, "_addr"}, {32'd0, pre_A},      64'd0);
      check_val({tag, "_data"}, {32'd0, pre_data},   64'd0);
      check_val({tag, "_flags"}, {60'd0, busy, done, err, cpu_rst}, 64'b0001);
   endtask

   task automatic two_word_load(input int gap, input bit chk_rdy);
      logic [7:0] s[$];
      s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      sb_q.push_back({32'h0, 32'h12345678});
      sb_q.push_back({32'h4, 32'hDEADBEEF});
      do_start();
      send(s, gap, chk_rdy);
      check_val("pre_done", {63'd0, done}, 64'd0);
      @(posedge clk); #1;
      check_val("done", {62'd0, done, cpu_rst}, 64'b10);
      check_val("sb_empty", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      logic [7:0] s[$];
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("rst");
      rst = 1'b0;
      @(posedge clk); #1;

      // Two-word back-to-back load with latency check
      two_word_load(0, 1'b0);
      check_val("latency", 64'(cyc - t_start + 1), 64'd13);

      // Zero-length image
      do_start();
      s = '{8'h00, 8'h00};
      send(s, 0, 1'b0);
      check_val("zero_done", {61'd0, done, cpu_rst, busy}, 64'b100);

      // Overflow header then a valid one-word reload
      do_start();
      s = '{8'h01, 8'h01};
      send(s, 0, 1'b0);
      check_val("ovf_err", {61'd0, err, cpu_rst, done}, 64'b110);
      repeat (2) @(posedge clk);
      #1;
      check_val("ovf_sticky", {63'd0, err}, 64'd1);
      do_start();
      check_val("ovf_clr", {63'd0, err}, 64'd0);
      s = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      sb_q.push_back({32'h0, 32'h44332211});
      send(s, 0, 1'b0);
      @(posedge clk); #1;
      check_val("ovf_reload", {61'd0, done, err, cpu_rst}, 64'b100);
      check_val("sb_empty2", 64'(sb_q.size()), 64'd0);

      // Gapped stream
      two_word_load(3, 1'b1);

      // Reset after two payload bytes
      do_start();
      s = '{8'h01, 8'h00, 8'hAA, 8'hBB};
      send(s, 0, 1'b0);
      check_val("mid_busy", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      #1;
      check_reset_vals("arst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      two_word_load(0, 1'b0);

      // Start pulsed mid-DATA is ignored; start in DONE reloads from BASE
      do_start();
      s = '{8'h02, 8'h00, 8'h78, 8'h56};
      sb_q.push_back({32'h0, 32'h12345678});
      sb_q.push_back({32'h4, 32'hDEADBEEF});
      send(s, 0, 1'b0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_val("ign_busy", {62'd0, busy, done}, 64'b10);
      check_val("ign_part", {48'd0, pre_data[15:0]}, 64'h5678);
      s = '{8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      send(s, 0, 1'b0);
      @(posedge clk); #1;
      check_val("ign_done", {62'd0, done, cpu_rst}, 64'b10);
      check_val("sb_empty3", 64'(sb_q.size()), 64'd0);
      do_start();
      check_val("reld_edge", {61'd0, done, cpu_rst, busy}, 64'b011);
      check_val("reld_addr", {32'd0, pre_A}, 64'd0);
      s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      sb_q.push_back({32'h0, 32'h04030201});
      send(s, 0, 1'b0);
      @(posedge clk); #1;
      check_val("reld_done", {62'd0, done, cpu_rst}, 64'b10);
      check_val("sb_empty4", 64'(sb_q.size()), 64'd0);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
